// File: rtl/axis_fifo_rd_ctrl.sv
// axis_fifo_rd_ctrl
//   Read-side sequencer between a FIFO core read port and an AXI-Stream master.
//   Reads are issued ahead of demand on a credit basis. Credits are the words
//   buffered plus the reads still in flight. Returning data lands in a small
//   circular skid buffer. This hides the fixed RAM read latency and sustains one
//   beat per cycle. m_axis_tready never reaches o_fifo_ren combinationally.
//
// Parameters
//   DLEN       data width in bits
//   RLAT       cycles from o_fifo_ren sampled high to valid i_fifo_rdata (1..4)
//   BUF_DEPTH  skid buffer entries, must be >= RLAT+2 for full throughput
//
// Ports
//   clk            clock
//   rstn           synchronous active-low reset
//   o_fifo_ren     read enable to FIFO core
//   i_fifo_rdata   read data from FIFO core, valid RLAT cycles after ren
//   i_fifo_rempty  FIFO core empty flag
//   m_axis_tvalid  AXI-Stream valid (buffer not empty)
//   m_axis_tready  AXI-Stream ready
//   m_axis_tdata   AXI-Stream data (head of skid buffer)
//   o_level        entries buffered plus reads in flight
//   o_beat_cnt     handshake counter, wrapping (only with AXIS_FIFO_RD_CTRL_STATS_EN)
//   o_stall_cnt    valid-without-ready cycles, saturating (only with AXIS_FIFO_RD_CTRL_STATS_EN)
//
// Optional feature macro: AXIS_FIFO_RD_CTRL_STATS_EN
module axis_fifo_rd_ctrl #(
    parameter int DLEN      = 8,
    parameter int RLAT      = 2,
    parameter int BUF_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    output logic                           o_fifo_ren,
    input  logic [DLEN-1:0]                i_fifo_rdata,
    input  logic                           i_fifo_rempty,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [DLEN-1:0]                m_axis_tdata,
`ifdef AXIS_FIFO_RD_CTRL_STATS_EN
    output logic [31:0]                    o_beat_cnt,
    output logic [31:0]                    o_stall_cnt,
`endif
    output logic [$clog2(BUF_DEPTH+1)-1:0] o_level
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);

    if (RLAT < 1 || RLAT > 4) begin : g_bad_rlat
        $error("axis_fifo_rd_ctrl: RLAT must be in 1..4");
    end
    if (BUF_DEPTH < RLAT + 2) begin : g_bad_depth
        $error("axis_fifo_rd_ctrl: BUF_DEPTH must be >= RLAT+2");
    end

    logic [CW-1:0]   cnt;
    logic [CW-1:0]   buf_cnt;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [RLAT-1:0] ren_vld_p;
    logic [DLEN-1:0] mem [BUF_DEPTH];
    logic            hs;
    logic            land;

    // Pointers wrap by compare-and-reset so non power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Issue depends only on the empty flag and the registered credit count.
    always_comb begin
        o_fifo_ren = rstn && !i_fifo_rempty && (cnt < DEPTH_C);
    end

    assign hs            = m_axis_tvalid && m_axis_tready;
    assign land          = ren_vld_p[RLAT-1];
    assign m_axis_tvalid = (buf_cnt != '0);
    // The head entry is gated by valid. Storage is never reset, so tdata still reads 0 out of reset.
    assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : '0;
    assign o_level       = cnt;

    // Stage boundary: issue -> in-flight shift register / credit and buffer state
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt       <= '0;
            buf_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ren_vld_p <= '0;
        end else begin
            ren_vld_p[0] <= o_fifo_ren;
            for (int i = 1; i < RLAT; i++) begin
                ren_vld_p[i] <= ren_vld_p[i-1];
            end

            case ({o_fifo_ren, hs})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase

            // A landing word and a pop in the same cycle cancel out. This also holds when
            // only one word is buffered, because the write goes to a different slot than the head.
            case ({land, hs})
                2'b10:   buf_cnt <= buf_cnt + 1'b1;
                2'b01:   buf_cnt <= buf_cnt - 1'b1;
                default: buf_cnt <= buf_cnt;
            endcase

            if (land) wr_ptr <= ptr_inc(wr_ptr);
            if (hs)   rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    // Stage boundary: read data capture into skid buffer
    always_ff @(posedge clk) begin
        if (land) mem[wr_ptr] <= i_fifo_rdata;
    end

`ifdef AXIS_FIFO_RD_CTRL_STATS_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_beat_cnt  <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (hs) o_beat_cnt <= o_beat_cnt + 32'd1;
            if (m_axis_tvalid && !m_axis_tready) o_stall_cnt <= sat_inc32(o_stall_cnt);
        end
    end
`endif

endmodule
